muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_unit                                                  |
// | Description : Multi-cycle RV32M execute unit (fixed-latency multiply,      |
// |               radix-2 restoring divide). Optional MULDIV_EARLY_OUT_EN      |
// |               finishes divide-by-zero and signed overflow at accept time.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            mul_stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mul  = 2'd1;
    localparam logic [1:0] c_div  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [4:0]      r_count;
    logic [1:0]      r_f3;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div_zero;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_early;
    logic [XLEN-1:0] w_early_res;
    logic            w_b_zero;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    assign w_accept = (r_state == c_idle) & start & ~flush;
    assign w_b_zero = (op_b == '0);
    assign w_a_neg  = ~funct3[0] & op_a[XLEN-1];
    assign w_b_neg  = ~funct3[0] & op_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? ('0 - op_a) : op_a;
    assign w_b_mag  = w_b_neg ? ('0 - op_b) : op_b;

`ifdef MULDIV_EARLY_OUT_EN
    logic w_ovf;
    assign w_ovf       = ~funct3[0] & (op_a == 32'h8000_0000) & (&op_b);
    assign w_early     = funct3[2] & (w_b_zero | w_ovf);
    assign w_early_res = w_b_zero ? (funct3[1] ? op_a : '1)
                                  : (funct3[1] ? '0 : 32'h8000_0000);
`else
    assign w_early     = 1'b0;
    assign w_early_res = '0;
`endif

    // Multiplier reads live inputs in IDLE so a latency of 1 can finish from accept
    logic [XLEN-1:0]   w_mul_a;
    logic [XLEN-1:0]   w_mul_b;
    logic [1:0]        w_mul_f;
    logic signed [32:0] w_ma;
    logic signed [32:0] w_mb;
    logic [63:0]       w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_mul_a   = (r_state == c_idle) ? op_a : r_a;
    assign w_mul_b   = (r_state == c_idle) ? op_b : r_b;
    assign w_mul_f   = (r_state == c_idle) ? funct3[1:0] : r_f3;
    assign w_ma      = {(w_mul_f[0] ^ w_mul_f[1]) & w_mul_a[XLEN-1], w_mul_a};
    assign w_mb      = {(w_mul_f == 2'b01) & w_mul_b[XLEN-1], w_mul_b};
    assign w_prod    = 64'(w_ma) * 64'(w_mb);
    assign w_mul_res = (w_mul_f == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // r_a shifts dividend bits out and quotient bits in
    logic [32:0]     w_shift;
    logic [32:0]     w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_div_res;

    assign w_shift   = {r_rem, r_a[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_ge      = ~w_diff[32];
    assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_a[XLEN-2:0], w_ge};
    assign w_q_fix   = r_div_zero ? '1 : (r_neg_q ? ('0 - w_quo_nxt) : w_quo_nxt);
    assign w_r_fix   = r_neg_r ? ('0 - w_rem_nxt) : w_rem_nxt;
    assign w_div_res = r_f3[1] ? w_r_fix : w_q_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    if (w_early)                 w_next_state = c_done;
                    else if (funct3[2])          w_next_state = c_div;
                    else if (MUL_LATENCY == 1)   w_next_state = c_done;
                    else                         w_next_state = c_mul;
                end
            end
            c_mul: begin
                if (flush)                  w_next_state = c_idle;
                else if (r_count == 5'd1)   w_next_state = c_done;
            end
            c_div: begin
                if (flush)                  w_next_state = c_idle;
                else if (r_count == 5'd0)   w_next_state = c_done;
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_f3       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_f3       <= funct3[1:0];
                        r_count    <= funct3[2] ? 5'd31 : 5'(MUL_LATENCY - 1);
                        r_a        <= funct3[2] ? w_a_mag : op_a;
                        r_b        <= funct3[2] ? w_b_mag : op_b;
                        r_rem      <= '0;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= w_b_zero;
                        if (w_early)
                            r_result <= w_early_res;
                        else if (!funct3[2] && MUL_LATENCY == 1)
                            r_result <= w_mul_res;
                    end
                end
                c_mul: begin
                    if (!flush) begin
                        r_count <= r_count - 5'd1;
                        if (r_count == 5'd1) r_result <= w_mul_res;
                    end
                end
                c_div: begin
                    if (!flush) begin
                        r_a     <= w_quo_nxt;
                        r_rem   <= w_rem_nxt;
                        r_count <= r_count - 5'd1;
                        if (r_count == 5'd0) r_result <= w_div_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_stall    = w_accept | (r_state == c_mul) | (r_state == c_div);
    assign result       = r_result;
    assign result_valid = (r_state == c_done);

endmodule
`default_nettype wire
